// File: rtl/tpu_avalon_sequencer.sv
// Avalon-MM slave front end and phase sequencer for the systolic TPU core.
// Optional feature: define TPU_IRQ_EN to add the irq output and the CTRL IRQ_EN bit.
module tpu_avalon_sequencer #(
  parameter int DATA_WIDTH     = 32,
  parameter int ARRAY_DIM      = 16,
  parameter int ADDR_WIDTH     = 10,
  parameter int MEM_ADDR_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ADDR_WIDTH-1:0]     slave_address,
  input  logic                      slave_read,
  input  logic                      slave_write,
  input  logic [DATA_WIDTH-1:0]     slave_writedata,
  input  logic [DATA_WIDTH/8-1:0]   slave_byteenable,
  output logic [DATA_WIDTH-1:0]     slave_readdata,
  output logic                      wr_en_weight,
  output logic                      wr_en_data,
  output logic [MEM_ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0]     wr_data,
  output logic [MEM_ADDR_WIDTH-1:0] base_addr_weight,
  output logic [MEM_ADDR_WIDTH-1:0] base_addr_data,
  output logic                      wr_en_fifo,
  output logic                      load_en_weight,
  output logic                      mult_en,
  output logic [MEM_ADDR_WIDTH-1:0] out_rd_addr,
  input  logic [DATA_WIDTH-1:0]     out_rd_data
`ifdef TPU_IRQ_EN
  ,
  output logic                      irq
`endif
);

  localparam int ROWS_W = MEM_ADDR_WIDTH + 1;
  localparam int CNT_W  = 32;
  localparam logic [CNT_W-1:0] PHASE_LAST = CNT_W'(ARRAY_DIM - 1);
  localparam logic [CNT_W-1:0] MULT_ADJ   = CNT_W'(2 * ARRAY_DIM - 3);

  localparam logic [1:0] RGN_CTRL   = 2'b00;
  localparam logic [1:0] RGN_WEIGHT = 2'b01;
  localparam logic [1:0] RGN_INPUT  = 2'b10;
  localparam logic [1:0] RGN_OUTPUT = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FIFO  = 3'd1,
    S_LOADW = 3'd2,
    S_MULT  = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      wr_en_fifo_q, wr_en_fifo_d;
  logic                      load_en_weight_q, load_en_weight_d;
  logic                      mult_en_q, mult_en_d;

  logic [MEM_ADDR_WIDTH-1:0] base_w_q, base_w_d;
  logic [MEM_ADDR_WIDTH-1:0] base_d_q, base_d_d;
  logic [ROWS_W-1:0]         rows_q, rows_d;
  logic                      irq_en_q, irq_en_d;
  logic                      done_q, done_d;
  logic                      err_q, err_d;
  logic [31:0]               cycles_q, cycles_d;
  logic [DATA_WIDTH-1:0]     readdata_q, readdata_d;
  logic                      wr_en_weight_q, wr_en_weight_d;
  logic                      wr_en_data_q, wr_en_data_d;
  logic [MEM_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]     wr_data_q, wr_data_d;
  logic                      irq_q, irq_d;

  logic [1:0]            region;
  logic [2:0]            reg_off;
  logic                  busy;
  logic                  ctrl_wr;
  logic                  start_req;
  logic                  start_ok;
  logic                  mem_wr;
  logic                  cfg_wr;
  logic                  err_set;
  logic [DATA_WIDTH-1:0] be_mask;

  assign region  = slave_address[ADDR_WIDTH-1 -: 2];
  assign reg_off = slave_address[2:0];
  assign busy    = (state_q != S_IDLE);
  assign ctrl_wr = slave_write && (region == RGN_CTRL);
  assign mem_wr  = slave_write && ((region == RGN_WEIGHT) || (region == RGN_INPUT));
  assign cfg_wr  = ctrl_wr && ((reg_off == 3'd2) || (reg_off == 3'd3) || (reg_off == 3'd5));

  assign start_req = ctrl_wr && (reg_off == 3'd0) && slave_byteenable[0] && slave_writedata[0];
  assign start_ok  = start_req && !busy && (rows_q != '0);
  assign err_set   = (start_req && (busy || (rows_q == '0))) || (mem_wr && busy) || (cfg_wr && busy);

  always_comb begin
    be_mask = '0;
    for (int i = 0; i < DATA_WIDTH / 8; i++) begin
      be_mask[i*8 +: 8] = {8{slave_byteenable[i]}};
    end
  end

  // State register and registered phase enables.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= S_IDLE;
      cnt_q            <= '0;
      wr_en_fifo_q     <= 1'b0;
      load_en_weight_q <= 1'b0;
      mult_en_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      wr_en_fifo_q     <= wr_en_fifo_d;
      load_en_weight_q <= load_en_weight_d;
      mult_en_q        <= mult_en_d;
    end
  end

  // Each phase down-counts to zero; the MULT count is loaded from ROWS at the LOADW exit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          state_d = S_FIFO;
          cnt_d   = PHASE_LAST;
        end
      end
      S_FIFO: begin
        if (cnt_q == '0) begin
          state_d = S_LOADW;
          cnt_d   = PHASE_LAST;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_LOADW: begin
        if (cnt_q == '0) begin
          state_d = S_MULT;
          cnt_d   = CNT_W'(rows_q) + MULT_ADJ;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_MULT: begin
        if (cnt_q == '0) begin
          state_d = S_FIN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_en_fifo_d     = (state_d == S_FIFO);
    load_en_weight_d = (state_d == S_LOADW);
    mult_en_d        = (state_d == S_MULT);
  end

  always_comb begin
    base_w_d = base_w_q;
    base_d_d = base_d_q;
    rows_d   = rows_q;
    irq_en_d = irq_en_q;
    done_d   = done_q;
    err_d    = err_q;
    cycles_d = cycles_q;

    if (cfg_wr && !busy) begin
      case (reg_off)
        3'd2: base_w_d = MEM_ADDR_WIDTH'((DATA_WIDTH'(base_w_q) & ~be_mask) | (slave_writedata & be_mask));
        3'd3: base_d_d = MEM_ADDR_WIDTH'((DATA_WIDTH'(base_d_q) & ~be_mask) | (slave_writedata & be_mask));
        3'd5: rows_d   = ROWS_W'((DATA_WIDTH'(rows_q) & ~be_mask) | (slave_writedata & be_mask));
        default: ;
      endcase
    end

`ifdef TPU_IRQ_EN
    if (ctrl_wr && (reg_off == 3'd0) && slave_byteenable[0]) irq_en_d = slave_writedata[1];
`else
    irq_en_d = 1'b0;
`endif

    if (ctrl_wr && (reg_off == 3'd1) && slave_byteenable[0]) begin
      if (slave_writedata[1]) done_d = 1'b0;
      if (slave_writedata[2]) err_d  = 1'b0;
    end
    if (start_ok) done_d = 1'b0;
    // Completion outranks a simultaneous clear so a finished run is never lost.
    if (state_q == S_FIN) done_d = 1'b1;
    if (err_set) err_d = 1'b1;

    if (start_ok) begin
      cycles_d = '0;
    end else if (busy && (cycles_q != '1)) begin
      cycles_d = cycles_q + 1'b1;
    end
  end

  always_comb begin
    readdata_d = readdata_q;
    if (slave_read) begin
      readdata_d = '0;
      case (region)
        RGN_CTRL: begin
          case (reg_off)
            3'd0: readdata_d = DATA_WIDTH'({irq_en_q, 1'b0});
            3'd1: readdata_d = DATA_WIDTH'({err_q, done_q, busy});
            3'd2: readdata_d = DATA_WIDTH'(base_w_q);
            3'd3: readdata_d = DATA_WIDTH'(base_d_q);
            3'd4: readdata_d = DATA_WIDTH'(cycles_q);
            3'd5: readdata_d = DATA_WIDTH'(rows_q);
            default: readdata_d = '0;
          endcase
        end
        RGN_OUTPUT: readdata_d = out_rd_data;
        default:    readdata_d = '0;
      endcase
    end
  end

  always_comb begin
    wr_en_weight_d = slave_write && (region == RGN_WEIGHT) && !busy;
    wr_en_data_d   = slave_write && (region == RGN_INPUT) && !busy;
    wr_addr_d      = wr_addr_q;
    wr_data_d      = wr_data_q;
    if (mem_wr && !busy) begin
      wr_addr_d = slave_address[MEM_ADDR_WIDTH-1:0];
      wr_data_d = slave_writedata;
    end
    irq_d = (done_d || err_d) && irq_en_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_w_q       <= '0;
      base_d_q       <= '0;
      rows_q         <= '0;
      irq_en_q       <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
      cycles_q       <= '0;
      readdata_q     <= '0;
      wr_en_weight_q <= 1'b0;
      wr_en_data_q   <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      irq_q          <= 1'b0;
    end else begin
      base_w_q       <= base_w_d;
      base_d_q       <= base_d_d;
      rows_q         <= rows_d;
      irq_en_q       <= irq_en_d;
      done_q         <= done_d;
      err_q          <= err_d;
      cycles_q       <= cycles_d;
      readdata_q     <= readdata_d;
      wr_en_weight_q <= wr_en_weight_d;
      wr_en_data_q   <= wr_en_data_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
      irq_q          <= irq_d;
    end
  end

  assign slave_readdata   = readdata_q;
  assign wr_en_weight     = wr_en_weight_q;
  assign wr_en_data       = wr_en_data_q;
  assign wr_addr          = wr_addr_q;
  assign wr_data          = wr_data_q;
  assign base_addr_weight = base_w_q;
  assign base_addr_data   = base_d_q;
  assign wr_en_fifo       = wr_en_fifo_q;
  assign load_en_weight   = load_en_weight_q;
  assign mult_en          = mult_en_q;
  assign out_rd_addr      = slave_address[MEM_ADDR_WIDTH-1:0];

`ifdef TPU_IRQ_EN
  assign irq = irq_q;
`else
  logic unused_irq;
  assign unused_irq = irq_q;
`endif

endmodule

// File: tb/tb_tpu_avalon_sequencer.sv
// Scoreboard-driven bench for tpu_avalon_sequencer with ARRAY_DIM=4.
module tb_tpu_avalon_sequencer;

  localparam int DW = 32;
  localparam int AD = 4;
  localparam int AW = 10;
  localparam int MW = 8;

  localparam logic [AW-1:0] A_CTRL   = 10'h000;
  localparam logic [AW-1:0] A_STATUS = 10'h001;
  localparam logic [AW-1:0] A_BASEW  = 10'h002;
  localparam logic [AW-1:0] A_BASED  = 10'h003;
  localparam logic [AW-1:0] A_CYCLES = 10'h004;
  localparam logic [AW-1:0] A_ROWS   = 10'h005;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] slave_address;
  logic          slave_read;
  logic          slave_write;
  logic [DW-1:0] slave_writedata;
  logic [3:0]    slave_byteenable;
  logic [DW-1:0] slave_readdata;
  logic          wr_en_weight, wr_en_data;
  logic [MW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [MW-1:0] base_addr_weight, base_addr_data;
  logic          wr_en_fifo, load_en_weight, mult_en;
  logic [MW-1:0] out_rd_addr;
  logic [DW-1:0] out_rd_data;
`ifdef TPU_IRQ_EN
  logic          irq;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [DW-1:0] sb[$];

  always #5 clk = ~clk;

  tpu_avalon_sequencer #(
    .DATA_WIDTH(DW), .ARRAY_DIM(AD), .ADDR_WIDTH(AW), .MEM_ADDR_WIDTH(MW)
  ) dut (
    .clk(clk), .reset(reset),
    .slave_address(slave_address), .slave_read(slave_read), .slave_write(slave_write),
    .slave_writedata(slave_writedata), .slave_byteenable(slave_byteenable),
    .slave_readdata(slave_readdata),
    .wr_en_weight(wr_en_weight), .wr_en_data(wr_en_data), .wr_addr(wr_addr), .wr_data(wr_data),
    .base_addr_weight(base_addr_weight), .base_addr_data(base_addr_data),
    .wr_en_fifo(wr_en_fifo), .load_en_weight(load_en_weight), .mult_en(mult_en),
    .out_rd_addr(out_rd_addr), .out_rd_data(out_rd_data)
`ifdef TPU_IRQ_EN
    , .irq(irq)
`endif
  );

  task automatic bus_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
    @(negedge clk);
    slave_address = a; slave_writedata = d; slave_byteenable = be; slave_write = 1'b1;
    @(negedge clk);
    slave_write = 1'b0;
  endtask

  task automatic bus_read(input logic [AW-1:0] a, output logic [DW-1:0] q);
    @(negedge clk);
    slave_address = a; slave_read = 1'b1;
    @(negedge clk);
    slave_read = 1'b0;
    q = slave_readdata;
  endtask

  // Samples phase enables for a fixed window starting at the current cycle.
  task automatic count_phases(input int window, output int nf, output int nl, output int nm,
                              output int overlap);
    nf = 0; nl = 0; nm = 0; overlap = 0;
    for (int i = 0; i < window; i++) begin
      if (wr_en_fifo === 1'b1) nf++;
      if (load_en_weight === 1'b1) nl++;
      if (mult_en === 1'b1) nm++;
      if ((32'(wr_en_fifo) + 32'(load_en_weight) + 32'(mult_en)) > 1) overlap++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    logic [DW-1:0] got, e;
    vectors++;
    if ({wr_en_fifo, load_en_weight, mult_en, wr_en_weight, wr_en_data} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_enables got=%b exp=00000",
               {wr_en_fifo, load_en_weight, mult_en, wr_en_weight, wr_en_data});
    end
    sb.push_back(32'h0); bus_read(A_STATUS, got); e = sb.pop_front(); vectors++;
    if (got !== e) begin miscompares++; $display("FAIL reset_status got=%h exp=%h", got, e); end
    sb.push_back(32'h0); bus_read(A_CYCLES, got); e = sb.pop_front(); vectors++;
    if (got !== e) begin miscompares++; $display("FAIL reset_cycles got=%h exp=%h", got, e); end
    sb.push_back(32'h0); bus_read(A_BASEW, got); e = sb.pop_front(); vectors++;
    if (got !== e) begin miscompares++; $display("FAIL reset_basew got=%h exp=%h", got, e); end
  endtask

  task automatic test_mem_write;
    bus_write(10'h105, 32'hDEADBEEF, 4'hF);
    vectors++;
    if ({wr_en_weight, wr_en_data, wr_addr, wr_data} !== {1'b1, 1'b0, 8'h05, 32'hDEADBEEF}) begin
      miscompares++;
      $display("FAIL weight_write got we=%b wd=%b a=%h d=%h exp we=1 wd=0 a=05 d=deadbeef",
               wr_en_weight, wr_en_data, wr_addr, wr_data);
    end
    @(negedge clk);
    vectors++;
    if (wr_en_weight !== 1'b0) begin
      miscompares++; $display("FAIL weight_pulse_width got=%b exp=0", wr_en_weight);
    end
    bus_write(10'h20A, 32'h00C0FFEE, 4'hF);
    vectors++;
    if ({wr_en_weight, wr_en_data, wr_addr, wr_data} !== {1'b0, 1'b1, 8'h0A, 32'h00C0FFEE}) begin
      miscompares++;
      $display("FAIL input_write got we=%b wd=%b a=%h d=%h exp we=0 wd=1 a=0a d=00c0ffee",
               wr_en_weight, wr_en_data, wr_addr, wr_data);
    end
  endtask

  task automatic test_cfg_regs;
    logic [DW-1:0] got, e;
    bus_write(A_BASEW, 32'h0000005A, 4'hF);
    bus_write(A_BASEW, 32'h0000FFFF, 4'h2);
    vectors++;
    if (base_addr_weight !== 8'h5A) begin
      miscompares++; $display("FAIL basew_byteenable got=%h exp=5a", base_addr_weight);
    end
    bus_write(A_BASED, 32'h00000033, 4'hF);
    vectors++;
    if (base_addr_data !== 8'h33) begin
      miscompares++; $display("FAIL based_port got=%h exp=33", base_addr_data);
    end
    bus_write(A_ROWS, 32'hFFFFFFFF, 4'hF);
    sb.push_back(32'h1FF); bus_read(A_ROWS, got); e = sb.pop_front(); vectors++;
    if (got !== e) begin miscompares++; $display("FAIL rows_width got=%h exp=%h", got, e); end
    bus_write(10'h006, 32'hFFFFFFFF, 4'hF);
    sb.push_back(32'h0); bus_read(10'h006, got); e = sb.pop_front(); vectors++;
    if (got !== e) begin miscompares++; $display("FAIL offset6_read got=%h exp=%h", got, e); end
    sb.push_back(32'h0); bus_read(10'h105, got); e = sb.pop_front(); vectors++;
    if (got !== e) begin miscompares++; $display("FAIL weight_region_read got=%h exp=%h", got, e); end
`ifndef TPU_IRQ_EN
    bus_write(A_CTRL, 32'h2, 4'hF);
    sb.push_back(32'h0); bus_read(A_CTRL, got); e = sb.pop_front(); vectors++;
    if (got !== e) begin miscompares++; $display("FAIL ctrl_irqen_ro got=%h exp=%h", got, e); end
`endif
  endtask

  task automatic test_rows_zero;
    logic [DW-1:0] got, e;
    bus_write(A_ROWS, 32'h0, 4'hF);
    bus_write(A_CTRL, 32'h1, 4'hF);
    vectors++;
    if (wr_en_fifo !== 1'b0) begin
      miscompares++; $display("FAIL rows0_no_start got=%b exp=0", wr_en_fifo);
    end
    sb.push_back(32'h4); bus_read(A_STATUS, got); e = sb.pop_front(); vectors++;
    if (got !== e) begin miscompares++; $display("FAIL rows0_status got=%h exp=%h", got, e); end
    bus_write(A_STATUS, 32'h4, 4'hF);
    sb.push_back(32'h0); bus_read(A_STATUS, got); e = sb.pop_front(); vectors++;
    if (got !== e) begin miscompares++; $display("FAIL err_w1c got=%h exp=%h", got, e); end
  endtask

  task automatic test_full_run;
    logic [DW-1:0] got, e;
    int nf, nl, nm, ov;
    bus_write(A_ROWS, 32'h3, 4'hF);
    bus_write(A_CTRL, 32'h1, 4'hF);
    count_phases(40, nf, nl, nm, ov);
    vectors++;
    if ({nf, nl, nm, ov} !== {32'd4, 32'd4, 32'd9, 32'd0}) begin
      miscompares++;
      $display("FAIL run_phase_lengths got=%0d/%0d/%0d ov=%0d exp=4/4/9 ov=0", nf, nl, nm, ov);
    end
    sb.push_back(32'h2); bus_read(A_STATUS, got); e = sb.pop_front(); vectors++;
    if (got !== e) begin miscompares++; $display("FAIL run_done got=%h exp=%h", got, e); end
    sb.push_back(32'd18); bus_read(A_CYCLES, got); e = sb.pop_front(); vectors++;
    if (got !== e) begin miscompares++; $display("FAIL run_cycles got=%0d exp=%0d", got, e); end
  endtask

  task automatic test_back_to_back;
    logic [DW-1:0] got, e, got_mid, e_mid;
    int nf, nl, nm, ov;
    bus_write(A_CTRL, 32'h1, 4'hF);
    fork
      count_phases(40, nf, nl, nm, ov);
      begin
        repeat (2) @(negedge clk);
        bus_write(A_CTRL, 32'h1, 4'hF);
        bus_write(10'h101, 32'h11, 4'hF);
        sb.push_back(32'h5);
        bus_read(A_STATUS, got_mid);
      end
    join
    e_mid = sb.pop_front(); vectors++;
    if (got_mid !== e_mid) begin
      miscompares++; $display("FAIL busy_status got=%h exp=%h", got_mid, e_mid);
    end
    vectors++;
    if ({nf, nl, nm, ov} !== {32'd4, 32'd4, 32'd9, 32'd0}) begin
      miscompares++;
      $display("FAIL busy_start_lengths got=%0d/%0d/%0d ov=%0d exp=4/4/9 ov=0", nf, nl, nm, ov);
    end
    sb.push_back(32'h6); bus_read(A_STATUS, got); e = sb.pop_front(); vectors++;
    if (got !== e) begin miscompares++; $display("FAIL busy_err_done got=%h exp=%h", got, e); end
    sb.push_back(32'd18); bus_read(A_CYCLES, got); e = sb.pop_front(); vectors++;
    if (got !== e) begin miscompares++; $display("FAIL busy_cycles got=%0d exp=%0d", got, e); end
    bus_write(A_STATUS, 32'h6, 4'hF);
  endtask

  task automatic test_reset_mid_run;
    logic [DW-1:0] got, e;
    bus_write(A_CTRL, 32'h1, 4'hF);
    repeat (9) @(negedge clk);
    vectors++;
    if (mult_en !== 1'b1) begin miscompares++; $display("FAIL pre_reset_mult got=%b exp=1", mult_en); end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({wr_en_fifo, load_en_weight, mult_en} !== 3'b000) begin
      miscompares++;
      $display("FAIL async_reset_enables got=%b exp=000", {wr_en_fifo, load_en_weight, mult_en});
    end
    @(negedge clk);
    reset = 1'b0;
    sb.push_back(32'h0); bus_read(A_STATUS, got); e = sb.pop_front(); vectors++;
    if (got !== e) begin miscompares++; $display("FAIL midrun_status got=%h exp=%h", got, e); end
    sb.push_back(32'h0); bus_read(A_BASEW, got); e = sb.pop_front(); vectors++;
    if (got !== e) begin miscompares++; $display("FAIL midrun_basew got=%h exp=%h", got, e); end
  endtask

  task automatic test_out_read;
    logic [DW-1:0] got, e;
    out_rd_data = 32'h1234;
    @(negedge clk);
    slave_address = 10'h303; slave_read = 1'b1;
    #1;
    vectors++;
    if (out_rd_addr !== 8'h03) begin miscompares++; $display("FAIL out_rd_addr got=%h exp=03", out_rd_addr); end
    sb.push_back(32'h1234);
    @(negedge clk);
    slave_read = 1'b0;
    out_rd_data = 32'h9999;
    got = slave_readdata; e = sb.pop_front(); vectors++;
    if (got !== e) begin miscompares++; $display("FAIL out_read_data got=%h exp=%h", got, e); end
    sb.push_back(32'h1234);
    repeat (2) @(negedge clk);
    got = slave_readdata; e = sb.pop_front(); vectors++;
    if (got !== e) begin miscompares++; $display("FAIL readdata_hold got=%h exp=%h", got, e); end
  endtask

`ifdef TPU_IRQ_EN
  task automatic test_irq;
    logic [DW-1:0] got, e;
    int waited;
    bus_write(A_ROWS, 32'h3, 4'hF);
    bus_write(A_CTRL, 32'h2, 4'hF);
    sb.push_back(32'h2); bus_read(A_CTRL, got); e = sb.pop_front(); vectors++;
    if (got !== e) begin miscompares++; $display("FAIL irqen_readback got=%h exp=%h", got, e); end
    bus_write(A_CTRL, 32'h3, 4'hF);
    waited = 0;
    while (irq !== 1'b1 && waited < 60) begin @(negedge clk); waited++; end
    vectors++;
    if (irq !== 1'b1) begin miscompares++; $display("FAIL irq_assert got=%b exp=1", irq); end
    bus_write(A_STATUS, 32'h2, 4'hF);
    vectors++;
    if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_clear got=%b exp=0", irq); end
  endtask
`endif

  initial begin
    reset = 1'b1;
    slave_address = '0; slave_read = 1'b0; slave_write = 1'b0;
    slave_writedata = '0; slave_byteenable = 4'h0; out_rd_data = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_mem_write();
    test_cfg_regs();
    test_rows_zero();
    test_full_run();
    test_back_to_back();
    test_reset_mid_run();
    test_out_read();
`ifdef TPU_IRQ_EN
    test_irq();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
